// File: rtl/encoder_8x3.sv
// Registered 8-to-3 one-hot encoder with valid/err flags.
// Define PRIORITY_EN to have a multi-hot input encode its highest set bit instead of forcing index 0.
module encoder_8x3 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] dec_i,
  output logic [2:0] bin_o,
  output logic       valid_o,
  output logic       err_o
);

  logic [2:0] bin_d, bin_q;
  logic       valid_d, valid_q;
  logic       err_d, err_q;
  logic       any_set;
  logic       multi;
  logic [2:0] idx;

  assign any_set = |dec_i;
  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  assign multi   = |(dec_i & (dec_i - 8'd1));

`ifdef PRIORITY_EN
  // The highest set bit wins, so later loop iterations overwrite earlier ones.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (dec_i[i]) idx = 3'(i);
  end
`else
  // OR-reduction encode; a multi-hot input is forced to index 0 further down.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (dec_i[i]) idx = idx | 3'(i);
  end
`endif

  always_comb begin
    bin_d   = 3'd0;
    valid_d = 1'b0;
    err_d   = multi;
`ifdef PRIORITY_EN
    if (any_set) begin
      bin_d   = idx;
      valid_d = 1'b1;
    end
`else
    if (any_set && !multi) begin
      bin_d   = idx;
      valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q   <= 3'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (en_i) begin
      bin_q   <= bin_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bin_o   = bin_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_encoder_8x3.sv
// Directed-vector bench for encoder_8x3; expected values are {bin, valid, err}.
module tb_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] dec = 8'h00;
  logic [2:0] bin;
  logic       valid;
  logic       err;
  int         nvec = 0;
  int         nmis = 0;

  encoder_8x3 dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .dec_i   (dec),
    .bin_o   (bin),
    .valid_o (valid),
    .err_o   (err)
  );

  always #5 clk = ~clk;

`ifdef PRIORITY_EN
  localparam logic [4:0] EXP_C1 = {3'd7, 1'b1, 1'b1};
  localparam logic [4:0] EXP_05 = {3'd2, 1'b1, 1'b1};
  localparam logic [4:0] EXP_FF = {3'd7, 1'b1, 1'b1};
`else
  localparam logic [4:0] EXP_C1 = {3'd0, 1'b0, 1'b1};
  localparam logic [4:0] EXP_05 = {3'd0, 1'b0, 1'b1};
  localparam logic [4:0] EXP_FF = {3'd0, 1'b0, 1'b1};
`endif

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got bin=%0d valid=%0b err=%0b, want bin=%0d valid=%0b err=%0b",
               tag, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Drive on the falling edge, then sample 1ns after the next rising edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [7:0] d,
                      input logic [4:0] exp);
    @(negedge clk);
    rst = r;
    en  = e;
    dec = d;
    @(posedge clk);
    #1;
    chk(tag, {bin, valid, err}, exp);
  endtask

  initial begin
    step("reset0", 1'b1, 1'b1, 8'hFF, 5'b000_0_0);
    step("reset1", 1'b1, 1'b1, 8'hFF, 5'b000_0_0);

    for (int i = 0; i < 8; i++)
      step($sformatf("sweep%0d", i), 1'b0, 1'b1, 8'(1 << i), {3'(i), 1'b1, 1'b0});

    step("zero",  1'b0, 1'b1, 8'h00, 5'b000_0_0);
    step("mh_C1", 1'b0, 1'b1, 8'hC1, EXP_C1);
    step("hold_err", 1'b0, 1'b0, 8'h01, EXP_C1);
    step("mh_05", 1'b0, 1'b1, 8'h05, EXP_05);
    step("mh_FF", 1'b0, 1'b1, 8'hFF, EXP_FF);
    step("mh_03", 1'b0, 1'b1, 8'h03,
`ifdef PRIORITY_EN
         {3'd1, 1'b1, 1'b1}
`else
         {3'd0, 1'b0, 1'b1}
`endif
    );

    step("en_10",  1'b0, 1'b1, 8'h10, {3'd4, 1'b1, 1'b0});
    step("hold_a", 1'b0, 1'b0, 8'h02, {3'd4, 1'b1, 1'b0});
    step("hold_b", 1'b0, 1'b0, 8'h02, {3'd4, 1'b1, 1'b0});
    step("reen",   1'b0, 1'b1, 8'h02, {3'd1, 1'b1, 1'b0});

    // Reset pulse mid-sweep, then the sweep resumes with the next line.
    step("rs_01", 1'b0, 1'b1, 8'h01, {3'd0, 1'b1, 1'b0});
    step("rs_02", 1'b0, 1'b1, 8'h02, {3'd1, 1'b1, 1'b0});
    step("rs_04", 1'b0, 1'b1, 8'h04, {3'd2, 1'b1, 1'b0});
    step("rs_pulse", 1'b1, 1'b1, 8'h08, 5'b000_0_0);
    step("rs_08", 1'b0, 1'b1, 8'h08, {3'd3, 1'b1, 1'b0});
    step("rs_10", 1'b0, 1'b1, 8'h10, {3'd4, 1'b1, 1'b0});

    // Reset must win even when en is low.
    step("rst_en0", 1'b1, 1'b0, 8'h40, 5'b000_0_0);
    step("post_rst_en0", 1'b0, 1'b0, 8'h40, 5'b000_0_0);
    step("post_rst_en1", 1'b0, 1'b1, 8'h40, {3'd6, 1'b1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
